pkt_width_down_conv: RTL and testbench
======================================

// Module: pkt_width_down_conv
// PURPOSE
//  Parametrised wide-to-narrow packet converter. Takes IN_W-bit packet words plus a per-packet metadata word carrying byte length.
//  Emits OUT_W-bit AXI-Stream beats with tkeep/tlast and true tready backpressure, all in one clock domain.
//  Sits between the 512-bit packet pipeline and narrow MAC/PCIe TX interfaces.
// PARAMETERS
//  IN_W        512  input data width, bits; multiple of OUT_W
//  OUT_W       8    output data width, bits; multiple of 8
//  MD_W        112  metadata width, bits
//  LEN_LSB     96   bit position of length field in metadata
//  LEN_W       11   length field width, bytes
//  DATA_DEPTH  64   data FIFO depth, words; power of 2
//  MD_DEPTH    128  metadata FIFO depth, entries; power of 2
//  AF_MARGIN   8    almost-full threshold margin, entries
// PORTS
//  clk           in   1             clock
//  rst_n         in   1             async reset, active low
//  in_data       in   IN_W          packet word; byte 0 at [IN_W-1:IN_W-8]
//  in_data_wr    in   1             write strobe for in_data
//  in_md         in   MD_W          packet metadata; length at [LEN_LSB+LEN_W-1:LEN_LSB]
//  in_md_wr      in   1             write strobe for in_md
//  in_alf        out  1             almost full, to upstream
//  out_tdata     out  OUT_W         output beat; first byte in MSBs
//  out_tkeep     out  OUT_W/8       byte enables, MSB-first contiguous
//  out_tvalid    out  1             beat valid
//  out_tlast     out  1             last beat of packet
//  out_tready    in   1             downstream ready
//  err_zero_len  out  1             1-cycle pulse: zero-length metadata discarded
//  err_ovf       out  1             sticky: write to a full FIFO was dropped
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFOs flushed; state IDLE; out_tdata/tkeep/tvalid/tlast, err_* and counters = 0; packet aborted.
//  - FIFOs are first-word-fall-through. Write to a full FIFO: the write is dropped and err_ovf is set until reset.
//  - in_alf = (data_cnt >= DATA_DEPTH-AF_MARGIN) | (md_cnt >= MD_DEPTH-AF_MARGIN).
//  - FSM IDLE: if md FIFO is non-empty, pop md.
//    - len==0: pulse err_zero_len, consume no data word, stay IDLE.
//    - Else latch rem=len and lane=0; go to SEND.
//  - FSM SEND: the output register loads when (!out_tvalid | out_tready) and the data FIFO is non-empty.
//    - tdata = word[IN_W-1-lane*OUT_W -: OUT_W].
//    - Not last beat (rem > OUT_W/8): tkeep all ones, tlast=0, rem -= OUT_W/8.
//    - Last beat (rem <= OUT_W/8): tkeep = rem MSB ones, tlast=1.
//  - Data word pop: after the last lane of a word (lane==IN_W/OUT_W-1), and also on the last beat of the packet.
//  - After the last beat of a packet:
//    - If md is non-empty with len!=0: pop md and start the next packet with no bubble.
//    - Otherwise go to IDLE.
//  - Data FIFO empty in SEND: no load; out_tvalid drops once the current beat is accepted; resumes when data arrives.
//  - AXI-S rule: while out_tvalid=1 and out_tready=0, tdata/tkeep/tlast hold stable.
//  - Latency: md+data present in IDLE -> first out_tvalid 2 cycles later. Throughput: 1 beat/clk with tready=1.
//  - Simultaneous FIFO write and read in one cycle is legal; count is unchanged.
// CONFIGURATION
//  PWDC_STATS_EN defined: adds ports pkt_out_cnt[31:0] and byte_out_cnt[31:0].
//    - pkt_out_cnt increments on each accepted tlast beat (tvalid&tready&tlast).
//    - byte_out_cnt adds popcount(tkeep) per accepted beat.
//    - Both wrap modulo 2^32 and reset to 0.
//  Not defined: ports and counters are absent; no other behaviour changes.
// STRUCTURE
//  - Shared package pwdc_pkg: FSM state enum {IDLE,SEND}, LEN field slice helper, tkeep-from-remaining function.
//  - One sub-module: pkt_sync_fifo (parametric width/depth, FWFT, count output), instantiated twice (data, md).
//  - Elaboration-time check: IN_W % OUT_W == 0 and OUT_W % 8 == 0.
// TESTING
//  T1: IN_W=512, OUT_W=8, md len=60, one word, tready=1 -> 60 beats bytes 0..59, tlast on beat 60, tkeep=1.
//  T2: OUT_W=64, len=13 -> beat1 tkeep=FF; beat2 tkeep=F8, tlast=1; next md popped without a bubble.
//  T3: len=130 (3 words), tready toggling 1/0 each clk -> 130 bytes in order, data stable while stalled, 3 data pops.
//  T4: md len=0 then len=4 -> err_zero_len pulses once; only the 4-byte packet is emitted.
//  T5: fill data FIFO to 56 words with out_tready=0 -> in_alf=1; 65th word -> err_ovf=1 and the word is dropped.
//  T6: rst_n low mid-packet -> outputs 0 immediately; after release, a new len=8 packet is emitted cleanly (STATS: pkt_out_cnt=1, byte_out_cnt=8).

Source files
------------

// File: rtl/pwdc_pkg.sv
// Shared types and helpers for the packet width down-converter.
package pwdc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Upper bounds for the helper functions below; the top checks its
  // parameters against these at elaboration.
  localparam int unsigned MD_MAX_W = 512;
  localparam int unsigned KEEP_MAX = 256;

  // Extract a w-bit field starting at bit lsb of a metadata word.
  function automatic logic [31:0] len_field(input logic [MD_MAX_W-1:0] md,
                                            input int unsigned lsb,
                                            input int unsigned w);
    logic [MD_MAX_W-1:0] sh;
    logic [31:0]         mask;
    sh   = md >> lsb;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return sh[31:0] & mask;
  endfunction

  // Byte enables for a beat of bpb bytes when rem bytes remain:
  // MSB-first contiguous ones, all ones once rem reaches bpb.
  function automatic logic [KEEP_MAX-1:0] keep_from_rem(input int unsigned rem,
                                                        input int unsigned bpb);
    logic [KEEP_MAX-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if ((i < bpb) && ((i + rem) >= bpb)) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/pkt_width_down_conv_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Writes to a full FIFO are dropped and flagged on ovf for that cycle.
module pkt_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign ovf     = wr_en & full;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pkt_width_down_conv.sv
// Wide-to-narrow packet converter: IN_W-bit packet words plus per-packet
// metadata (byte length) in, OUT_W-bit AXI-Stream beats with tkeep/tlast out.
// Optional build macro PWDC_STATS_EN adds pkt_out_cnt / byte_out_cnt.
module pkt_width_down_conv
  import pwdc_pkg::*;
#(
  parameter int unsigned IN_W       = 512,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned MD_W       = 112,
  parameter int unsigned LEN_LSB    = 96,
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned DATA_DEPTH = 64,
  parameter int unsigned MD_DEPTH   = 128,
  parameter int unsigned AF_MARGIN  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_data_wr,
  input  logic [MD_W-1:0]      in_md,
  input  logic                 in_md_wr,
  output logic                 in_alf,
  output logic [OUT_W-1:0]     out_tdata,
  output logic [OUT_W/8-1:0]   out_tkeep,
  output logic                 out_tvalid,
  output logic                 out_tlast,
  input  logic                 out_tready,
`ifdef PWDC_STATS_EN
  output logic [31:0]          pkt_out_cnt,
  output logic [31:0]          byte_out_cnt,
`endif
  output logic                 err_zero_len,
  output logic                 err_ovf
);

  localparam int unsigned BPB       = OUT_W / 8;
  localparam int unsigned LANES     = IN_W / OUT_W;
  localparam int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned DCW       = $clog2(DATA_DEPTH) + 1;
  localparam int unsigned MCW       = $clog2(MD_DEPTH) + 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  if (((IN_W % OUT_W) != 0) || ((OUT_W % 8) != 0)) begin : g_bad_width
    $error("pkt_width_down_conv: IN_W must be a multiple of OUT_W and OUT_W a multiple of 8");
  end
  if ((MD_W > MD_MAX_W) || (BPB > KEEP_MAX)) begin : g_bad_limits
    $error("pkt_width_down_conv: MD_W or OUT_W exceeds pwdc_pkg limits");
  end

  // FIFO interfaces
  logic [IN_W-1:0]  data_rd;
  logic             data_empty, data_pop, data_ovf;
  logic [DCW-1:0]   data_cnt;
  logic [MD_W-1:0]  md_rd;
  logic             md_empty, md_pop, md_ovf;
  logic [MCW-1:0]   md_cnt;
  logic [LEN_W-1:0] md_len;

  // Registered state
  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [OUT_W-1:0]   tdata_q, tdata_d;
  logic [BPB-1:0]     tkeep_q, tkeep_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               zlen_q, zlen_d;
  logic               ovf_q, ovf_d;

  logic               can_load, last_beat;
  logic [OUT_W-1:0]   lane_word [LANES];

  pkt_sync_fifo #(
    .WIDTH (IN_W),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_data_wr),
    .wr_data (in_data),
    .rd_en   (data_pop),
    .rd_data (data_rd),
    .empty   (data_empty),
    .count   (data_cnt),
    .ovf     (data_ovf)
  );

  pkt_sync_fifo #(
    .WIDTH (MD_W),
    .DEPTH (MD_DEPTH)
  ) u_md_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_md_wr),
    .wr_data (in_md),
    .rd_en   (md_pop),
    .rd_data (md_rd),
    .empty   (md_empty),
    .count   (md_cnt),
    .ovf     (md_ovf)
  );

  // Lane g of the head word; lane 0 carries byte 0 in the MSBs.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_word[g] = data_rd[IN_W-1-g*OUT_W -: OUT_W];
  end

  assign md_len    = LEN_W'(len_field(MD_MAX_W'(md_rd), LEN_LSB, LEN_W));
  assign in_alf    = (32'(data_cnt) >= (DATA_DEPTH - AF_MARGIN)) ||
                     (32'(md_cnt)   >= (MD_DEPTH   - AF_MARGIN));
  assign can_load  = !tvalid_q || out_tready;
  assign last_beat = (32'(rem_q) <= BPB);

  // Next-state, beat formation and FIFO pop decisions.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    zlen_d   = 1'b0;
    ovf_d    = ovf_q | data_ovf | md_ovf;
    data_pop = 1'b0;
    md_pop   = 1'b0;

    // An accepted beat retires unless a new one is loaded below.
    if (tvalid_q && out_tready) tvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!md_empty) begin
          md_pop = 1'b1;
          if (md_len == '0) begin
            zlen_d = 1'b1;
          end else begin
            rem_d   = md_len;
            lane_d  = '0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (can_load && !data_empty) begin
          tvalid_d = 1'b1;
          tdata_d  = lane_word[lane_q];
          tkeep_d  = BPB'(keep_from_rem(32'(rem_q), BPB));
          if (!last_beat) begin
            tlast_d = 1'b0;
            rem_d   = rem_q - LEN_W'(BPB);
            if (lane_q == LAST_LANE) begin
              data_pop = 1'b1;
              lane_d   = '0;
            end else begin
              lane_d = lane_q + LANE_W'(1);
            end
          end else begin
            // Packet ends mid-word: the rest of the word is discarded.
            tlast_d  = 1'b1;
            data_pop = 1'b1;
            lane_d   = '0;
            if (!md_empty && (md_len != '0)) begin
              md_pop = 1'b1;
              rem_d  = md_len;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      lane_q   <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      zlen_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      lane_q   <= lane_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      zlen_q   <= zlen_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_tdata    = tdata_q;
  assign out_tkeep    = tkeep_q;
  assign out_tvalid   = tvalid_q;
  assign out_tlast    = tlast_q;
  assign err_zero_len = zlen_q;
  assign err_ovf      = ovf_q;

`ifdef PWDC_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;

  // Count accepted packets and bytes; both wrap naturally.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (tvalid_q && out_tready) begin
      byte_cnt_d = byte_cnt_q + 32'($countones(tkeep_q));
      if (tlast_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign pkt_out_cnt  = pkt_cnt_q;
  assign byte_out_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_width_down_conv.sv
// Self-checking bench for pkt_width_down_conv (IN_W=512, OUT_W=64).
module tb_pkt_width_down_conv;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [511:0]  in_data;
  logic          in_data_wr;
  logic [111:0]  in_md;
  logic          in_md_wr;
  logic          in_alf;
  logic [63:0]   out_tdata;
  logic [7:0]    out_tkeep;
  logic          out_tvalid;
  logic          out_tlast;
  logic          out_tready;
  logic          err_zero_len;
  logic          err_ovf;
`ifdef PWDC_STATS_EN
  logic [31:0]   pkt_out_cnt;
  logic [31:0]   byte_out_cnt;
`endif

  pkt_width_down_conv #(
    .IN_W       (512),
    .OUT_W      (64),
    .MD_W       (112),
    .LEN_LSB    (96),
    .LEN_W      (11),
    .DATA_DEPTH (64),
    .MD_DEPTH   (128),
    .AF_MARGIN  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_data_wr   (in_data_wr),
    .in_md        (in_md),
    .in_md_wr     (in_md_wr),
    .in_alf       (in_alf),
    .out_tdata    (out_tdata),
    .out_tkeep    (out_tkeep),
    .out_tvalid   (out_tvalid),
    .out_tlast    (out_tlast),
    .out_tready   (out_tready),
`ifdef PWDC_STATS_EN
    .pkt_out_cnt  (pkt_out_cnt),
    .byte_out_cnt (byte_out_cnt),
`endif
    .err_zero_len (err_zero_len),
    .err_ovf      (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t        exp_q[$];
  logic [511:0] mwords[$];
  int checks = 0;
  int errors = 0;
  int zl_exp = 0;
  int zl_seen = 0;
  int acc_cnt = 0;
  int rdy_mode = 0;   // 0: never ready, 1: always, 2: toggle, 3: random

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: packet bytes are the concatenated words, byte 0 first;
  // beat k carries bytes 8k..8k+7 with keep covering the bytes still in the packet.
  task automatic model_pkt(input int len);
    logic [7:0]   by[$];
    logic [511:0] wd;
    logic [7:0]   t;
    beat_t        b;
    int nw, nb, v;
    if (len == 0) begin
      zl_exp++;
      return;
    end
    nw = (len + 63) / 64;
    for (int w = 0; w < nw; w++) begin
      wd = (mwords.size() != 0) ? mwords.pop_front() : '0;
      for (int j = 0; j < 64; j++) by.push_back(wd[511-8*j -: 8]);
    end
    nb = (len + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      b.d = '0;
      for (int j = 0; j < 8; j++) b.d = {b.d[55:0], by[8*k+j]};
      v = len - 8*k;
      if (v >= 8) b.k = 8'hFF;
      else begin
        t = 8'hFF;
        b.k = t << (8 - v);
      end
      b.l = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wr_word(input logic [511:0] w, input bit wait_alf, input bit keep);
    int n = 0;
    while (wait_alf && in_alf === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("alf_wait_timeout", 1, 0);
    @(negedge clk);
    in_data    = w;
    in_data_wr = 1'b1;
    @(negedge clk);
    in_data_wr = 1'b0;
    if (keep) mwords.push_back(w);
  endtask

  task automatic wr_md(input int len);
    logic [111:0] md;
    md[31:0]   = $urandom();
    md[63:32]  = $urandom();
    md[95:64]  = $urandom();
    md[111:96] = 16'($urandom());
    md[96 +: 11] = 11'(len);
    @(negedge clk);
    in_md    = md;
    in_md_wr = 1'b1;
    @(negedge clk);
    in_md_wr = 1'b0;
    model_pkt(len);
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  task automatic send_pkt(input int len);
    int nw = (len + 63) / 64;
    for (int i = 0; i < nw; i++) wr_word(rand_word(), 1'b1, 1'b1);
    wr_md(len);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || out_tvalid === 1'b1) && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("drain_timeout", (n >= bound), 0);
  endtask

  // Ready driver and output scoreboard; sampled mid-cycle.
  initial begin
    beat_t b;
    out_tready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_tready = 1'b0;
        1:       out_tready = 1'b1;
        2:       out_tready = ~out_tready;
        default: out_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (err_zero_len === 1'b1) zl_seen++;
      if (out_tvalid === 1'b1 && out_tready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("unexpected_beat", out_tvalid, 0);
        else begin
          b = exp_q.pop_front();
          chk("tdata", out_tdata, b.d);
          chk("tkeep", out_tkeep, b.k);
          chk("tlast", out_tlast, b.l);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, zs, len;
    rst_n = 1'b0; in_data = '0; in_data_wr = 1'b0; in_md = '0; in_md_wr = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tdata", out_tdata, 0);
    chk("rst_tkeep", out_tkeep, 0);
    chk("rst_tlast", out_tlast, 0);
    chk("rst_zlen", err_zero_len, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_alf", in_alf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: 60-byte packet, first-beat latency, then drain
    rdy_mode = 0;
    send_pkt(60);
    @(negedge clk); #2;
    chk("lat_early", out_tvalid, 0);
    @(negedge clk); #2;
    chk("lat_first", out_tvalid, 1);
    rdy_mode = 1;
    wait_drain(200);

    // T2: two 13-byte packets back to back, no bubble between them
    rdy_mode = 0;
    send_pkt(13);
    send_pkt(13);
    repeat (10) @(negedge clk);
    #2;
    rdy_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("t2_cycles", n, 4);
    wait_drain(100);

    // T3: 130-byte packet across 3 words with toggling ready
    rdy_mode = 2;
    send_pkt(130);
    wait_drain(500);

    // T4: zero-length metadata is discarded
    rdy_mode = 1;
    zs = zl_seen;
    wr_md(0);
    send_pkt(4);
    wait_drain(200);
    chk("t4_zlen_pulses", zl_seen - zs, 1);

    // Random packets with random backpressure
    rdy_mode = 3;
    for (int i = 0; i < 24; i++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 300));
      send_pkt(len);
    end
    wait_drain(5000);
    chk("rand_zlen", zl_seen, zl_exp);

    // T5: fill data FIFO with no metadata, almost-full and overflow
    rdy_mode = 0;
    for (int i = 1; i <= 64; i++) begin
      wr_word(rand_word(), 1'b0, 1'b1);
      if (i == 55) chk("t5_alf_55", in_alf, 0);
      if (i == 56) chk("t5_alf_56", in_alf, 1);
    end
    chk("t5_ovf_before", err_ovf, 0);
    wr_word(rand_word(), 1'b0, 1'b0);
    chk("t5_ovf_after", err_ovf, 1);
    for (int i = 0; i < 4; i++) wr_md(1024);
    rdy_mode = 1;
    wait_drain(3000);
    chk("t5_alf_clear", in_alf, 0);
    send_pkt(8);
    wait_drain(200);
    chk("t5_ovf_sticky", err_ovf, 1);

    // T6: reset mid-packet, then a clean 8-byte packet
    rdy_mode = 1;
    send_pkt(200);
    c0 = acc_cnt;
    n = 0;
    while (acc_cnt - c0 < 3 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("t6_started", (acc_cnt - c0 >= 3), 1);
    chk("t6_pre_valid", out_tvalid, 1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_tvalid", out_tvalid, 0);
    chk("t6_tdata", out_tdata, 0);
    chk("t6_tkeep", out_tkeep, 0);
    chk("t6_tlast", out_tlast, 0);
    chk("t6_ovf", err_ovf, 0);
    chk("t6_alf", in_alf, 0);
    exp_q.delete();
    mwords.delete();
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
`ifdef PWDC_STATS_EN
    chk("t6_pkt_cnt_rst", pkt_out_cnt, 0);
    chk("t6_byte_cnt_rst", byte_out_cnt, 0);
`endif
    send_pkt(8);
    wait_drain(200);
`ifdef PWDC_STATS_EN
    chk("t6_pkt_cnt", pkt_out_cnt, 1);
    chk("t6_byte_cnt", byte_out_cnt, 8);
`endif
    chk("final_zlen", zl_seen, zl_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
